if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have one clock and synchronous active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous, active-high reset.
REQ-002 The block SHALL have the port flush  input  1  discards all queued entries (branch taken).
REQ-003 The block SHALL have the port in_valid  input  1  fetch stage presents a valid entry.
REQ-004 The block SHALL have the port in_pc  input  32  PC+4 of fetched instruction.
REQ-005 The block SHALL have the port in_instr  input  32  fetched instruction word.
REQ-006 The block SHALL have the port in_ready  output  1  queue can accept an entry this cycle.
REQ-007 The block SHALL have the port out_valid  output  1  head entry is valid for decode.
REQ-008 The block SHALL have the port out_pc  output  32  head entry PC.
REQ-009 The block SHALL have the port out_instr  output  32  head entry instruction.
REQ-010 The block SHALL have the port out_ready  input  1  decode consumes head entry this cycle.
REQ-011 The block SHALL have the port count  output  3  number of stored entries, 0..4.
REQ-012 The block SHALL have the parameter DEPTH, default 4, number of entries (fixed power of two; only 4 is supported).

Function
REQ-013 Storage SHALL be DEPTH entries of {pc[31:0], instr[31:0]}, written at wr_ptr and read at rd_ptr; both pointers are 2 bits and wrap 3->0.
REQ-014 Push SHALL occur when in_valid=1 and in_ready=1; entry is written at wr_ptr and wr_ptr increments on the same rising edge.
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1; rd_ptr increments on the rising edge.
REQ-016 in_ready SHALL equal (count != 4), combinationally from registered count only; no dependence on out_ready (no full-bypass).
REQ-017 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL combinationally show the entry at rd_ptr when out_valid=1 and 32'h0 when out_valid=0.
REQ-018 Latency SHALL be one cycle: an entry pushed at edge N is visible on outputs after edge N; no empty-queue bypass.
REQ-019 count SHALL update per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or neither.
REQ-020 Simultaneous push and pop SHALL be legal at any count 1..3, and at count 0 only push occurs (out_valid=0); at count 4 only pop occurs (in_ready=0).
REQ-021 flush=1 SHALL on the next edge set count=0, wr_ptr=0, rd_ptr=0, overriding any push or pop in that cycle; the entry presented with flush is discarded.
REQ-022 in_ready SHALL be 1 and out_valid SHALL be 0 in the cycle following a flush.
REQ-023 Entries SHALL leave in push order; no entry is dropped, duplicated or reordered except by flush/rst.
REQ-024 Storage contents SHALL NOT be cleared by flush; only pointers and count, since out_* mask on out_valid=0.

Reset
REQ-025 rst=1 at a rising edge SHALL set count=0, wr_ptr=0, rd_ptr=0, giving in_ready=1, out_valid=0, out_pc=0, out_instr=0.
REQ-026 rst SHALL take priority over flush, push and pop; reset mid-stream SHALL discard all entries.
REQ-027 Storage array SHALL NOT require reset.

Verification
REQ-028 Reset then push pc=4,instr=0x00220000 with out_ready=0 -> next cycle out_valid=1, out_pc=4, out_instr=0x00220000, count=1.
REQ-029 Push 4 entries (pc=4,8,12,16) with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; then out_ready=1 for 4 cycles -> out_pc 4,8,12,16 in order, count=0.
REQ-030 Fill to count=2, hold in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, outputs strictly ordered across pointer wrap 3->0.
REQ-031 count=3 with in_valid=1, out_ready=1, flush=1 -> next cycle count=0, out_valid=0, out_pc=0, in_ready=1; following push pc=0x40 appears as next head.
REQ-032 count=4 and rst=1 together with flush=1 and in_valid=1 -> next cycle count=0, in_ready=1, out_valid=0, out_instr=0.
REQ-033 Random in_valid/out_ready/flush for 10000 cycles against a reference queue model -> every popped {pc,instr} matches model, count never exceeds 4.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID pipeline queue: a small FIFO of {pc, instr} pairs between fetch and decode.
// Flush and reset clear pointers and occupancy; the storage array itself is never cleared.
module if_id_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic [2:0]  count
);

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic [1:0] wr_ptr_q;
    logic [1:0] wr_ptr_d;
    logic [1:0] rd_ptr_q;
    logic [1:0] rd_ptr_d;
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       push_s;
    logic       pop_s;

    // Handshake and head-entry outputs, all derived from registered state only
    always_comb begin
        in_ready  = (count_q != 3'd4);
        out_valid = (count_q != 3'd0);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready;
        count     = count_q;
        if (out_valid) begin
            out_pc    = pc_mem_q[rd_ptr_q];
            out_instr = instr_mem_q[rd_ptr_q];
        end else begin
            out_pc    = 32'h0;
            out_instr = 32'h0;
        end
    end

    // Next-state pointers and occupancy; flush overrides any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a write during flush/reset is harmless because the pointers restart
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
